// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID fields, downstream writeback info, and the EX-side outputs.
// master drives the decode/writeback side; slave is the ID/EX register itself.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic [AW-1:0] id_dst;
    logic [DW-1:0] id_rd1;
    logic [DW-1:0] id_rd2;
    logic [DW-1:0] id_imm;
    logic [5:0]    id_aluop;
    logic [4:0]    id_shamt;
    logic          id_usigned;
    logic [4:0]    id_ctrl;
    logic          flush;
    logic          exm_regwrite;
    logic [AW-1:0] exm_dst;
    logic [DW-1:0] exm_res;
    logic          wb_regwrite;
    logic [AW-1:0] wb_dst;
    logic [DW-1:0] wb_data;

    logic          stall;
    logic          ex_valid;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [DW-1:0] ex_store;
    logic [5:0]    ex_aluop;
    logic [4:0]    ex_shamt;
    logic          ex_usigned;
    logic [3:0]    ex_ctrl;
    logic [AW-1:0] ex_dst;

    modport master (
        output id_valid, id_rs, id_rt, id_dst, id_rd1, id_rd2, id_imm,
               id_aluop, id_shamt, id_usigned, id_ctrl, flush,
               exm_regwrite, exm_dst, exm_res, wb_regwrite, wb_dst, wb_data,
        input  stall, ex_valid, ex_a, ex_b, ex_store, ex_aluop, ex_shamt,
               ex_usigned, ex_ctrl, ex_dst
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dst, id_rd1, id_rd2, id_imm,
               id_aluop, id_shamt, id_usigned, id_ctrl, flush,
               exm_regwrite, exm_dst, exm_res, wb_regwrite, wb_dst, wb_data,
        output stall, ex_valid, ex_a, ex_b, ex_store, ex_aluop, ex_shamt,
               ex_usigned, ex_ctrl, ex_dst
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with RAW hazard handling.
// Macro FORWARD_EN: forward from EX/MEM and MEM/WB, stall only on load-use; undefined: stall on any RAW.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);
    // id_ctrl bit positions
    localparam int C_ALUSRC   = 0;
    localparam int C_MEMWRITE = 3;
    // ex_ctrl bit positions (id_ctrl shifted down by one)
    localparam int E_REGWRITE = 0;
    localparam int E_MEMREAD  = 1;

    logic          r_valid;
    logic [AW-1:0] r_dst;
    logic [DW-1:0] r_rd1;
    logic [DW-1:0] r_rd2;
    logic [DW-1:0] r_imm;
    logic [5:0]    r_aluop;
    logic [4:0]    r_shamt;
    logic          r_usigned;
    logic          r_alusrc;
    logic [3:0]    r_ctrl;

    logic          w_uses_rt;
    logic          w_hazard;
    logic          w_bubble;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

    // rt is a real source unless the immediate replaces it, except stores which still read it
    assign w_uses_rt = ~bus.id_ctrl[C_ALUSRC] | bus.id_ctrl[C_MEMWRITE];

`ifdef FORWARD_EN
    logic [AW-1:0] r_rs;
    logic [AW-1:0] r_rt;

    assign w_hazard = bus.id_valid & r_valid & r_ctrl[E_MEMREAD] & (r_dst != '0)
                    & ((bus.id_rs == r_dst) | (w_uses_rt & (bus.id_rt == r_dst)));

    // later assignment wins, so EX/MEM overrides MEM/WB
    always_comb begin
        w_fwd_rs = r_rd1;
        if (bus.wb_regwrite && (bus.wb_dst != '0) && (bus.wb_dst == r_rs))
            w_fwd_rs = bus.wb_data;
        if (bus.exm_regwrite && (bus.exm_dst != '0) && (bus.exm_dst == r_rs))
            w_fwd_rs = bus.exm_res;
    end

    always_comb begin
        w_fwd_rt = r_rd2;
        if (bus.wb_regwrite && (bus.wb_dst != '0) && (bus.wb_dst == r_rt))
            w_fwd_rt = bus.wb_data;
        if (bus.exm_regwrite && (bus.exm_dst != '0) && (bus.exm_dst == r_rt))
            w_fwd_rt = bus.exm_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs <= '0;
            r_rt <= '0;
        end else begin
            r_rs <= bus.id_rs;
            r_rt <= bus.id_rt;
        end
    end
`else
    function automatic logic f_raw(
        input logic [AW-1:0] src,
        input logic          ex_w,
        input logic [AW-1:0] ex_d,
        input logic          exm_w,
        input logic [AW-1:0] exm_d,
        input logic          wb_w,
        input logic [AW-1:0] wb_d
    );
        return (src != '0) && ((ex_w && (src == ex_d)) || (exm_w && (src == exm_d))
                               || (wb_w && (src == wb_d)));
    endfunction

    logic w_ex_writes;
    assign w_ex_writes = r_valid & r_ctrl[E_REGWRITE];

    assign w_hazard = bus.id_valid
                    & (f_raw(bus.id_rs, w_ex_writes, r_dst, bus.exm_regwrite, bus.exm_dst,
                             bus.wb_regwrite, bus.wb_dst)
                       | (w_uses_rt & f_raw(bus.id_rt, w_ex_writes, r_dst, bus.exm_regwrite,
                                            bus.exm_dst, bus.wb_regwrite, bus.wb_dst)));

    assign w_fwd_rs = r_rd1;
    assign w_fwd_rt = r_rd2;
`endif

    // flush takes priority: a squashed instruction never holds the front end
    assign bus.stall = ~rst & ~bus.flush & w_hazard;
    assign w_bubble  = bus.flush | w_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_dst     <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_imm     <= '0;
            r_aluop   <= '0;
            r_shamt   <= '0;
            r_usigned <= 1'b0;
            r_alusrc  <= 1'b0;
            r_ctrl    <= '0;
        end else begin
            r_rd1     <= bus.id_rd1;
            r_rd2     <= bus.id_rd2;
            r_imm     <= bus.id_imm;
            r_aluop   <= bus.id_aluop;
            r_shamt   <= bus.id_shamt;
            r_usigned <= bus.id_usigned;
            if (w_bubble) begin
                r_valid  <= 1'b0;
                r_dst    <= '0;
                r_alusrc <= 1'b0;
                r_ctrl   <= '0;
            end else begin
                r_valid  <= bus.id_valid;
                r_dst    <= bus.id_dst;
                r_alusrc <= bus.id_ctrl[C_ALUSRC];
                r_ctrl   <= bus.id_ctrl[4:1];
            end
        end
    end

    assign bus.ex_valid   = r_valid;
    assign bus.ex_a       = w_fwd_rs;
    assign bus.ex_store   = w_fwd_rt;
    assign bus.ex_b       = r_alusrc ? r_imm : w_fwd_rt;
    assign bus.ex_aluop   = r_aluop;
    assign bus.ex_shamt   = r_shamt;
    assign bus.ex_usigned = r_usigned;
    assign bus.ex_ctrl    = r_ctrl;
    assign bus.ex_dst     = r_dst;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios followed by random traffic against a reference model.
// Works in both builds; expectations follow FORWARD_EN.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    // what the model believes sits in EX
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, dst;
        logic [31:0] rd1, rd2, imm;
        logic [5:0]  aluop;
        logic [4:0]  shamt;
        logic        usg;
        logic        alusrc;
        logic [3:0]  ctrl;   // RegWrite, MemRead, MemWrite, MemtoReg
    } ent_t;

    ent_t m;
    bit   m_data_ok;
    int   vectors = 0;
    int   miscompares = 0;
    logic last_stall;
    int   stalls;

    localparam logic [4:0] CT_ALU = 5'b00010;
    localparam logic [4:0] CT_LW  = 5'b10111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] regval);
`ifdef FORWARD_EN
        if (bus.exm_regwrite && bus.exm_dst != 0 && bus.exm_dst == src) return bus.exm_res;
        if (bus.wb_regwrite && bus.wb_dst != 0 && bus.wb_dst == src) return bus.wb_data;
`else
        if (src == 5'd0) return regval;
`endif
        return regval;
    endfunction

    function automatic logic writer_hits(input logic [4:0] r);
        if (r == 0) return 1'b0;
        return (m.valid && m.ctrl[0] && r == m.dst) || (bus.exm_regwrite && r == bus.exm_dst)
            || (bus.wb_regwrite && r == bus.wb_dst);
    endfunction

    function automatic logic exp_stall();
        logic uses_rt;
        if (rst || bus.flush || !bus.id_valid) return 1'b0;
        uses_rt = !bus.id_ctrl[0] || bus.id_ctrl[3];
`ifdef FORWARD_EN
        return m.valid && m.ctrl[1] && m.dst != 0
            && (bus.id_rs == m.dst || (uses_rt && bus.id_rt == m.dst));
`else
        return writer_hits(bus.id_rs) || (uses_rt && writer_hits(bus.id_rt));
`endif
    endfunction

    // check the current cycle, update the model, then move to just after the next edge
    task automatic cyc();
        logic st;
        logic [31:0] ofs;
        #1;
        chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
        chk("ex_ctrl", 32'(bus.ex_ctrl), 32'(m.ctrl));
        chk("ex_dst", 32'(bus.ex_dst), 32'(m.dst));
        if (m_data_ok) begin
            ofs = fwd(m.rt, m.rd2);
            chk("ex_a", bus.ex_a, fwd(m.rs, m.rd1));
            chk("ex_store", bus.ex_store, ofs);
            chk("ex_b", bus.ex_b, m.alusrc ? m.imm : ofs);
            chk("ex_aluop", 32'(bus.ex_aluop), 32'(m.aluop));
            chk("ex_shamt", 32'(bus.ex_shamt), 32'(m.shamt));
            chk("ex_usigned", 32'(bus.ex_usigned), 32'(m.usg));
        end
        st = exp_stall();
        chk("stall", 32'(bus.stall), 32'(st));
        last_stall = bus.stall;
        if (rst) begin
            m = '0;
            m_data_ok = 1'b1;
        end else begin
            m.rs = bus.id_rs;   m.rt = bus.id_rt;
            m.rd1 = bus.id_rd1; m.rd2 = bus.id_rd2; m.imm = bus.id_imm;
            m.aluop = bus.id_aluop; m.shamt = bus.id_shamt; m.usg = bus.id_usigned;
            if (bus.flush || st) begin
                m.valid = 1'b0; m.dst = '0; m.alusrc = 1'b0; m.ctrl = '0;
                m_data_ok = 1'b0;
            end else begin
                m.valid = bus.id_valid; m.dst = bus.id_dst;
                m.alusrc = bus.id_ctrl[0]; m.ctrl = bus.id_ctrl[4:1];
                m_data_ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic [31:0] rd1, input logic [4:0] ctrl);
        bus.id_valid = v;   bus.id_rs = rs; bus.id_rt = rt; bus.id_dst = dst;
        bus.id_rd1 = rd1;   bus.id_rd2 = 32'h0000_0222; bus.id_imm = 32'h0000_0044;
        bus.id_aluop = 6'd2; bus.id_shamt = 5'd0; bus.id_usigned = 1'b0; bus.id_ctrl = ctrl;
        bus.flush = 1'b0;
    endtask

    task automatic set_fw(input logic ew, input logic [4:0] ed, input logic [31:0] er,
                          input logic ww, input logic [4:0] wd, input logic [31:0] wdat);
        bus.exm_regwrite = ew; bus.exm_dst = ed; bus.exm_res = er;
        bus.wb_regwrite = ww;  bus.wb_dst = wd;  bus.wb_data = wdat;
    endtask

    // downstream writeback traffic seen k cycles after the producer left EX
    task automatic pat(input int tid, input int k);
        set_fw(0, 0, 0, 0, 0, 0);
        if (tid == 2 && k == 1) set_fw(1, 3, 32'h10, 0, 0, 0);
        if (tid == 2 && k == 2) set_fw(0, 0, 0, 1, 3, 32'h10);
        if (tid == 4 && k == 0) set_fw(1, 6, 32'h1000, 0, 0, 0);
        if (tid == 4 && k == 1) set_fw(0, 0, 0, 1, 6, 32'h66);
    endtask

    task automatic rand_inputs();
        bus.id_valid = ($urandom_range(0, 7) != 0);
        bus.id_rs = 5'($urandom_range(0, 3));
        bus.id_rt = 5'($urandom_range(0, 3));
        bus.id_dst = 5'($urandom_range(0, 3));
        bus.id_rd1 = $urandom; bus.id_rd2 = $urandom; bus.id_imm = $urandom;
        bus.id_aluop = 6'($urandom); bus.id_shamt = 5'($urandom);
        bus.id_usigned = 1'($urandom); bus.id_ctrl = 5'($urandom);
        bus.flush = ($urandom_range(0, 7) == 0);
        bus.exm_regwrite = 1'($urandom); bus.exm_dst = 5'($urandom_range(0, 3));
        bus.exm_res = $urandom;
        bus.wb_regwrite = 1'($urandom); bus.wb_dst = 5'($urandom_range(0, 3));
        bus.wb_data = $urandom;
    endtask

    initial begin
        int k;
        // reset with random inputs
        rst = 1'b1;
        rand_inputs();
        @(posedge clk);
        #1;
        m = '0;
        m_data_ok = 1'b1;
        rand_inputs(); cyc();
        rand_inputs(); cyc();
        rst = 1'b0;

        // add r3,r1,r2 then sub r4,r3,r1
        set_fw(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 2, 3, 32'h11, CT_ALU); cyc();
        stalls = 0;
        for (k = 0; k < 6; k++) begin
            pat(2, k);
            set_id(1, 3, 1, 4, (k >= 3) ? 32'h10 : 32'hDEAD, CT_ALU);
            cyc();
            stalls += int'(last_stall);
            if (!last_stall) break;
        end
`ifdef FORWARD_EN
        chk("raw_stall_cycles", 32'(stalls), 32'd0);
`else
        chk("raw_stall_cycles", 32'(stalls), 32'd3);
`endif
        pat(2, k + 1);
        set_id(0, 0, 0, 0, 0, 0);
        #1 chk("exm_fwd_value", bus.ex_a, 32'h10);
        cyc();

        // EX/MEM beats MEM/WB for r5
        set_fw(0, 0, 0, 0, 0, 0);
        set_id(1, 5, 0, 7, 32'h55, CT_ALU); cyc();
        set_fw(1, 5, 32'hA, 1, 5, 32'hB);
        set_id(0, 0, 0, 0, 0, 0);
`ifdef FORWARD_EN
        #1 chk("exm_priority", bus.ex_a, 32'hA);
`else
        #1 chk("exm_priority", bus.ex_a, 32'h55);
`endif
        cyc();

        // load-use on r6
        set_fw(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 0, 6, 32'h0, CT_LW); cyc();
        set_id(1, 6, 1, 8, 32'hDEAD, CT_ALU);
        #1 chk("loaduse_stall", 32'(bus.stall), 32'd1);
        cyc();
        stalls = 0;
        for (k = 0; k < 6; k++) begin
            pat(4, k);
            set_id(1, 6, 1, 8, (k >= 2) ? 32'h66 : 32'hDEAD, CT_ALU);
            if (k == 0) #1 chk("loaduse_bubble", 32'(bus.ex_valid), 32'd0);
            cyc();
            stalls += int'(last_stall);
            if (!last_stall) break;
        end
`ifdef FORWARD_EN
        chk("loaduse_extra_stalls", 32'(stalls), 32'd0);
`else
        chk("loaduse_extra_stalls", 32'(stalls), 32'd2);
`endif
        pat(4, k + 1);
        set_id(0, 0, 0, 0, 0, 0);
        #1 chk("load_operand", bus.ex_a, 32'h66);
        cyc();

        // load-use coinciding with flush
        set_fw(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 0, 6, 32'h0, CT_LW); cyc();
        set_id(1, 6, 1, 8, 32'hDEAD, CT_ALU);
        bus.flush = 1'b1;
        #1 chk("flush_over_stall", 32'(bus.stall), 32'd0);
        cyc();
        set_id(0, 0, 0, 0, 0, 0);
        #1 chk("flush_bubble", 32'(bus.ex_valid), 32'd0);
        cyc();

        // reset while stalled
        set_id(1, 1, 0, 6, 32'h0, CT_LW); cyc();
        set_id(1, 6, 1, 8, 32'hDEAD, CT_ALU);
        rst = 1'b1;
        #1 chk("rst_stall_gate", 32'(bus.stall), 32'd0);
        cyc();
        rst = 1'b0;
        #1 chk("rst_release_stall", 32'(bus.stall), 32'd0);
        chk("rst_release_valid", 32'(bus.ex_valid), 32'd0);
        cyc();

        // register 0 is never forwarded
        set_fw(1, 0, 32'hFFFF, 0, 0, 0);
        set_id(1, 0, 0, 9, 32'h0, CT_ALU); cyc();
        set_id(0, 0, 0, 0, 0, 0);
        #1 chk("r0_not_forwarded", bus.ex_a, 32'h0);
        cyc();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 59) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
